// File: rtl/fp_align_shift_seq_pkg.sv
// Shared constants and state encoding for the FP alignment sequencer.
// Default widths for the half-precision add/sub path.
package fp_align_shift_seq_pkg;

    localparam int MANTISSA  = 10;
    localparam int EXPONENT  = 5;
    localparam int SHIFT_W   = 5;
    localparam int SAT_SHIFT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/fp_align_step.sv
// One 0-3 bit zero-fill right shift of the working mantissa, plus the OR of
// the bits that fall off the bottom.
module fp_align_step #(
    parameter int MW = 11
) (
    input  logic [MW-1:0] mant,
    input  logic [1:0]    step,
    output logic [MW-1:0] shifted,
    output logic          dropped
);

    logic [2:0] drop_vec;

    // Bit gi is lost only when the step moves it past bit 0.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_drop
            assign drop_vec[gi] = (2'(gi) < step) ? mant[gi] : 1'b0;
        end
    endgenerate

    assign shifted = mant >> step;
    assign dropped = |drop_vec;

endmodule

// File: rtl/fp_align_shift_seq.sv
// Multi-cycle mantissa alignment: shifts right by the clamped exponent
// difference in steps of up to 3 bits per cycle, collecting a sticky bit.
module fp_align_shift_seq
    import fp_align_shift_seq_pkg::*;
#(
    parameter int MANTISSA  = fp_align_shift_seq_pkg::MANTISSA,
    parameter int SHIFT_W   = fp_align_shift_seq_pkg::SHIFT_W,
    parameter int SAT_SHIFT = fp_align_shift_seq_pkg::SAT_SHIFT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MANTISSA:0]   in_mant,
    input  logic [SHIFT_W-1:0]  in_shift,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MANTISSA:0]   out_mant,
    output logic                out_sticky,
    output logic                busy
);

    localparam int MW = MANTISSA + 1;
    localparam logic [SHIFT_W-1:0] SAT_W = SHIFT_W'(SAT_SHIFT);

    align_state_t        state_reg;
    logic [MW-1:0]       mant_reg;
    logic                sticky_reg;
    logic [SHIFT_W-1:0]  rem_reg;
    logic                out_valid_reg;
    logic [MW-1:0]       out_mant_reg;
    logic                out_sticky_reg;

    logic [SHIFT_W-1:0]  shift_clamped;
    logic [1:0]          step;
    logic [MW-1:0]       step_mant;
    logic                step_dropped;

    // Clamping before the register keeps rem bounded by SAT_SHIFT.
    assign shift_clamped = (in_shift >= SAT_W) ? SAT_W : in_shift;
    assign step          = (rem_reg >= SHIFT_W'(3)) ? 2'd3 : rem_reg[1:0];

    fp_align_step #(
        .MW (MW)
    ) u_step (
        .mant    (mant_reg),
        .step    (step),
        .shifted (step_mant),
        .dropped (step_dropped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            mant_reg       <= '0;
            sticky_reg     <= 1'b0;
            rem_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_mant_reg   <= '0;
            out_sticky_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mant_reg   <= in_mant;
                        sticky_reg <= 1'b0;
                        rem_reg    <= shift_clamped;
                        if (shift_clamped == '0) begin
                            state_reg      <= DONE;
                            out_valid_reg  <= 1'b1;
                            out_mant_reg   <= in_mant;
                            out_sticky_reg <= 1'b0;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mant_reg   <= step_mant;
                    sticky_reg <= sticky_reg | step_dropped;
                    rem_reg    <= rem_reg - SHIFT_W'(step);
                    if (rem_reg == SHIFT_W'(step)) begin
                        state_reg      <= DONE;
                        out_valid_reg  <= 1'b1;
                        out_mant_reg   <= step_mant;
                        out_sticky_reg <= sticky_reg | step_dropped;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign out_valid  = out_valid_reg;
    assign out_mant   = out_mant_reg;
    assign out_sticky = out_sticky_reg;

endmodule

// File: tb/tb_fp_align_shift_seq.sv
// Randomized bench for fp_align_shift_seq against an arithmetic alignment model.
module tb_fp_align_shift_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_mant;
    logic [4:0]  in_shift;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_mant;
    logic        out_sticky;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_align_shift_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_shift   (in_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_sticky (out_sticky),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic shift with saturation at 12.
    function automatic int model_eff(input logic [4:0] s);
        return (int'(s) > 12) ? 12 : int'(s);
    endfunction

    function automatic logic [10:0] model_mant(input logic [10:0] m, input logic [4:0] s);
        int v;
        v = int'(m) / (1 << model_eff(s));
        return 11'(v);
    endfunction

    function automatic logic model_sticky(input logic [10:0] m, input logic [4:0] s);
        int v;
        v = int'(m) % (1 << model_eff(s));
        return (v != 0);
    endfunction

    function automatic int model_lat(input logic [4:0] s);
        return (model_eff(s) + 2) / 3 + 1;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", 32'(n < 50), 32'd1);
    endtask

    // Wait for out_valid, starting one cycle after the accept edge.
    task automatic wait_result(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_req(input logic [10:0] m, input logic [4:0] s, input int hold);
        int cyc;
        logic [10:0] em;
        logic es;
        em = model_mant(m, s);
        es = model_sticky(m, s);
        in_mant  = m;
        in_shift = s;
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(cyc);
        check("latency", 32'(cyc), 32'(model_lat(s)));
        check("out_mant", 32'(out_mant), 32'(em));
        check("out_sticky", 32'(out_sticky), 32'(es));
        check("done_in_ready", 32'(in_ready), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_mant", 32'(out_mant), 32'(em));
            check("hold_sticky", 32'(out_sticky), 32'(es));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        $display("req mant=%03h shift=%0d hold=%0d -> mant=%03h sticky=%0b lat=%0d",
                 m, s, hold, out_mant, out_sticky, cyc);
    endtask

    initial begin
        int cyc;
        bit seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_shift  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_mant", 32'(out_mant), 32'd0);
        check("rst_out_sticky", 32'(out_sticky), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases: nominal, zero shift, saturation, held result.
        run_req(11'h7FF, 5'd5, 0);
        run_req(11'h400, 5'd0, 0);
        run_req(11'h001, 5'd31, 0);
        run_req(11'h400, 5'd3, 3);
        run_req(11'h000, 5'd9, 1);
        run_req(11'h7FF, 5'd12, 0);
        run_req(11'h7FF, 5'd11, 0);

        // out_ready high while idle must not disturb anything.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_ready_busy", 32'(busy), 32'd0);
        check("idle_ready_valid", 32'(out_valid), 32'd0);

        // Reset in the second SHIFT cycle discards the request.
        in_mant  = 11'h5A5;
        in_shift = 5'd9;
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_mant", 32'(out_mant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        $display("req mant=5a5 shift=9 reset mid-shift -> discarded");

        // Back-to-back with in_valid held and out_ready high.
        out_ready = 1'b1;
        in_mant   = 11'h123;
        in_shift  = 5'd4;
        in_valid  = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_mant  = 11'h7F0;
        in_shift = 5'd7;
        wait_result(cyc);
        check("b2b_a_lat", 32'(cyc), 32'(model_lat(5'd4)));
        check("b2b_a_mant", 32'(out_mant), 32'(model_mant(11'h123, 5'd4)));
        check("b2b_a_sticky", 32'(out_sticky), 32'(model_sticky(11'h123, 5'd4)));
        @(posedge clk); #1;
        check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
        check("b2b_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_b_accepted", 32'(busy), 32'd1);
        wait_result(cyc);
        check("b2b_b_lat", 32'(cyc), 32'(model_lat(5'd7)));
        check("b2b_b_mant", 32'(out_mant), 32'(model_mant(11'h7F0, 5'd7)));
        check("b2b_b_sticky", 32'(out_sticky), 32'(model_sticky(11'h7F0, 5'd7)));
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_end_in_ready", 32'(in_ready), 32'd1);
        $display("req back-to-back 123/4 then 7f0/7 -> done");

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            run_req(11'($urandom), 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
